pc_update_unit: RTL and testbench

//  Program-counter register and next-PC logic for the single-cycle RV32I core.

---
 rtl/pc_update_unit.sv | 107 ++++++++++
 tb/tb_pc_update_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pc_update_unit.sv
// Program-counter register and next-PC selection for a single-cycle RV32I core.
// Chooses PC+4, PC+imm or rs1+imm from the decoded type and branch flags; all targets are word-aligned.
module pc_update_unit #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [22:0]     cword,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] r,
  output logic [XLEN-1:0] pc,
  input  logic [3:0]      ZCNVFlags
);

  typedef enum logic [3:0] {
    T_LOAD   = 4'd0,
    T_OPIMM  = 4'd1,
    T_STORE  = 4'd2,
    T_OPREG  = 4'd3,
    T_LUI    = 4'd4,
    T_AUIPC  = 4'd5,
    T_BRANCH = 4'd6,
    T_JALR   = 4'd7,
    T_JAL    = 4'd8
  } inst_type_e;

  typedef enum logic [2:0] {
    F_BEQ  = 3'b000,
    F_BNE  = 3'b001,
    F_BLT  = 3'b100,
    F_BGE  = 3'b101,
    F_BLTU = 3'b110,
    F_BGEU = 3'b111
  } branch_fun3_e;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_rel;
  logic [XLEN-1:0] w_reg_rel;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_next_pc;
  logic [3:0]      w_inst_type;
  logic [2:0]      w_fun3;
  logic            w_z;
  logic            w_c;
  logic            w_n;
  logic            w_v;
  logic            w_taken;
  logic            w_unused_cword;

  assign w_inst_type = cword[3:0];
  assign w_fun3      = cword[6:4];
  // Upper control bits belong to other datapath units.
  assign w_unused_cword = ^cword[22:7];

  assign w_z = ZCNVFlags[3];
  assign w_c = ZCNVFlags[2];
  assign w_n = ZCNVFlags[1];
  assign w_v = ZCNVFlags[0];

  assign w_pc_plus4 = r_pc + PC_STEP;
  assign w_pc_rel   = r_pc + imm;
  assign w_reg_rel  = r + imm;

  // Flags come from rs1 - rs2; C set means no borrow (rs1 >= rs2 unsigned).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_taken = 1'b0;
    case (w_fun3)
      F_BEQ:   w_taken = w_z;
      F_BNE:   w_taken = !w_z;
      F_BLT:   w_taken = w_n ^ w_v;
      F_BGE:   w_taken = !(w_n ^ w_v);
      F_BLTU:  w_taken = !w_c;
      F_BGEU:  w_taken = w_c;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_target = w_pc_plus4;
    case (w_inst_type)
      T_JAL:    w_target = w_pc_rel;
      T_JALR:   w_target = w_reg_rel;
      T_BRANCH: w_target = w_taken ? w_pc_rel : w_pc_plus4;
      default:  w_target = w_pc_plus4;
    endcase
  end

  // Fetch is word-aligned; this also provides the jalr LSB clear. No misalignment trap.
  assign w_next_pc = {w_target[XLEN-1:2], 2'b00};

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  assign pc = r_pc;

endmodule

// File: tb/tb_pc_update_unit.sv
// Self-checking bench for pc_update_unit: directed literal cases plus randomized traffic
// compared every cycle against a reference model driven by real rs1/rs2 operand values.
module tb_pc_update_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [22:0] cword = '0;
  logic [31:0] imm = '0;
  logic [31:0] r = '0;
  logic [31:0] pc;
  logic [3:0]  ZCNVFlags;

  // Operands of the branch compare; flags are derived from them like the ALU would.
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_pc = '0;
  bit          model_ok = 1'b0;

  pc_update_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .cword     (cword),
    .imm       (imm),
    .r         (r),
    .pc        (pc),
    .ZCNVFlags (ZCNVFlags)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_flags(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    logic z, c, n, v;
    d = a - b;
    z = (d == 32'd0);
    c = (a >= b);
    n = d[31];
    v = (a[31] != b[31]) && (d[31] != a[31]);
    return {z, c, n, v};
  endfunction

  assign ZCNVFlags = alu_flags(rs1, rs2);

  // Reference: decide the branch from the operands themselves, not from flag equations.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [3:0] t,
                                             input logic [2:0] f3, input logic [31:0] im,
                                             input logic [31:0] rv, input logic [31:0] a,
                                             input logic [31:0] b);
    bit take;
    logic [31:0] tgt;
    case (f3)
      3'd0:    take = (a == b);
      3'd1:    take = (a != b);
      3'd4:    take = ($signed(a) <  $signed(b));
      3'd5:    take = ($signed(a) >= $signed(b));
      3'd6:    take = (a <  b);
      3'd7:    take = (a >= b);
      default: take = 1'b0;
    endcase
    if (t == 4'd8)               tgt = cur + im;
    else if (t == 4'd7)          tgt = rv + im;
    else if (t == 4'd6 && take)  tgt = cur + im;
    else                         tgt = cur + 32'd4;
    return tgt & ~32'd3;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      exp_pc   <= 32'h0;
      model_ok <= 1'b1;
    end else if (model_ok) begin
      exp_pc <= model_next(exp_pc, cword[3:0], cword[6:4], imm, r, rs1, rs2);
    end
  end

  always @(negedge clk) begin
    if (model_ok) check("model", pc, exp_pc);
  end

  // Apply one cycle of inputs (upper cword bits randomized) and return at the following negedge.
  task automatic step(input logic rst_v, input logic [3:0] t, input logic [2:0] f3,
                      input logic [31:0] im, input logic [31:0] rv,
                      input logic [31:0] a, input logic [31:0] b);
    rst   = rst_v;
    cword = {16'($urandom), f3, t};
    imm   = im;
    r     = rv;
    rs1   = a;
    rs2   = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_pc(input string name, input logic [31:0] lit);
    check(name, pc, lit);
    check({name, "/model"}, exp_pc, lit);
  endtask

  task automatic set_pc(input logic [31:0] v);
    step(1'b0, 4'd7, 3'($urandom), 32'd0, v, $urandom, $urandom);
  endtask

  initial begin
    @(negedge clk);
    // Reset dominates any control word.
    step(1'b1, 4'd8, 3'd0, 32'h0000_1000, 32'h55, 0, 0);
    expect_pc("reset", 32'h0);
    step(1'b1, 4'd7, 3'd0, 32'h40, 32'h80, 0, 0);
    expect_pc("reset_hold", 32'h0);

    step(1'b0, 4'd1, 3'd0, 32'h123, 32'h0, 0, 0);  expect_pc("opimm1", 32'd4);
    step(1'b0, 4'd1, 3'd0, 32'h123, 32'h0, 0, 0);  expect_pc("opimm2", 32'd8);
    step(1'b0, 4'd1, 3'd0, 32'h123, 32'h0, 0, 0);  expect_pc("opimm3", 32'd12);
    step(1'b0, 4'd5, 3'd0, 32'h7F0, 32'h0, 0, 0);  expect_pc("auipc1", 32'd16);
    step(1'b0, 4'd5, 3'd0, 32'h7F0, 32'h0, 0, 0);  expect_pc("auipc2", 32'd20);
    step(1'b0, 4'd5, 3'd0, 32'h7F0, 32'h0, 0, 0);  expect_pc("auipc3", 32'd24);

    step(1'b0, 4'd7, 3'd0, 32'd15, 32'd9, 0, 1);   expect_pc("jalr1", 32'd24);
    step(1'b0, 4'd7, 3'd0, 32'd15, 32'd9, 0, 1);   expect_pc("jalr2", 32'd24);
    step(1'b0, 4'd7, 3'd0, 32'd15, 32'd10, 0, 1);  expect_pc("jalr_align", 32'd24);

    set_pc(32'd0);                                  expect_pc("set0", 32'd0);
    step(1'b0, 4'd6, 3'd0, 32'd16, 32'h0, 0, 1);   expect_pc("beq_nt1", 32'd4);
    step(1'b0, 4'd6, 3'd0, 32'd16, 32'h0, 0, 1);   expect_pc("beq_nt2", 32'd8);
    step(1'b0, 4'd6, 3'd0, 32'd16, 32'h0, 5, 5);   expect_pc("beq_t1", 32'd24);
    step(1'b0, 4'd6, 3'd0, 32'd16, 32'h0, 5, 5);   expect_pc("beq_t2", 32'd40);
    step(1'b0, 4'd6, 3'd0, 32'd15, 32'h0, 5, 5);   expect_pc("beq_align", 32'd52);

    // rs1=0, rs2=1 gives N=1, V=0, C=0, Z=0.
    set_pc(32'd100); step(1'b0, 4'd6, 3'd4, 32'hFFFF_FFF8, 32'h0, 0, 1); expect_pc("blt", 32'd92);
    set_pc(32'd100); step(1'b0, 4'd6, 3'd5, 32'hFFFF_FFF8, 32'h0, 0, 1); expect_pc("bge", 32'd104);
    set_pc(32'd100); step(1'b0, 4'd6, 3'd6, 32'hFFFF_FFF8, 32'h0, 0, 1); expect_pc("bltu", 32'd92);
    set_pc(32'd100); step(1'b0, 4'd6, 3'd7, 32'hFFFF_FFF8, 32'h0, 0, 1); expect_pc("bgeu", 32'd104);
    set_pc(32'd100); step(1'b0, 4'd6, 3'd2, 32'hFFFF_FFF8, 32'h0, 5, 5); expect_pc("fun3_010", 32'd104);
    set_pc(32'd100); step(1'b0, 4'd6, 3'd1, 32'hFFFF_FFF8, 32'h0, 5, 5); expect_pc("bne_nt", 32'd104);

    set_pc(32'hFFFF_FFFC);                          expect_pc("set_top", 32'hFFFF_FFFC);
    step(1'b0, 4'd0, 3'd0, 32'h0, 32'h0, 0, 0);    expect_pc("wrap", 32'h0);
    step(1'b0, 4'd8, 3'd0, 32'hFFFF_FFFC, 32'h0, 0, 0); expect_pc("jal_neg", 32'hFFFF_FFFC);
    set_pc(32'd8);
    step(1'b0, 4'd12, 3'd0, 32'h40, 32'h80, 5, 5); expect_pc("illegal", 32'd12);

    // Reset in mid-stream, then resume from RESET_PC.
    step(1'b1, 4'd8, 3'd0, 32'h400, 32'h0, 0, 0);  expect_pc("mid_reset", 32'h0);
    step(1'b0, 4'd1, 3'd0, 32'h400, 32'h0, 0, 0);  expect_pc("post_reset", 32'd4);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, b, im;
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 7) == 0) b = {~a[31], a[30:0]};
      im = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
      step($urandom_range(0, 63) == 0,
           ($urandom_range(0, 1) == 0) ? 4'($urandom_range(6, 8)) : 4'($urandom),
           3'($urandom), im, $urandom, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
